// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
package branch_resolve_queue_pkg;

  localparam int BRQ_ADDR_W = 3;
  localparam int BRQ_CNT_W  = 16;

  // One in-flight branch: predictor table address and the direction fetch guessed.
  typedef struct packed {
    logic [BRQ_ADDR_W-1:0] addr;
    logic                  pred;
  } brq_entry_t;

  // Ceiling log2 for pointer widths. Returns at least 1 so that DEPTH=2 still gets a 1-bit pointer.
  function automatic int brq_clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// Circular buffer of in-flight branch entries with occupancy tracking and a
// flush input that empties the queue and rewinds both pointers to slot 0.
module brq_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BRQ_ADDR_W + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,       // already qualified: caller guarantees a free slot
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,        // already qualified: caller guarantees not empty
  input  logic             flush,      // discards everything, including a same-cycle push
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = brq_clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  // Next pointer/occupancy: flush wins, otherwise push and pop act independently.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; a write during flush lands in a slot that is immediately treated as free.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= push_data;
  end

  assign head_data = mem[head_q];
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// Matches resolved branches against their fetch-time predictions in order,
// drives the predictor update port, flushes wrong-path entries on a mispredict
// and keeps resolve/mispredict statistics.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = BRQ_ADDR_W,
  parameter int CNT_W  = BRQ_CNT_W
) (
  input  logic              CLOCK,
  input  logic              INIT,
  input  logic              PUSH,
  input  logic [ADDR_W-1:0] PUSH_ADDR,
  input  logic              PUSH_PRED,
  input  logic              RESOLVE,
  input  logic              TAKEN,
  output logic              FULL,
  output logic              EMPTY,
  output logic              UPD_VALID,
  output logic [ADDR_W-1:0] UPD_ADDR,
  output logic              UPD_OUTCOME,
  output logic              MISPREDICT,
  output logic              RESOLVE_ERR,
  output logic              OVERFLOW,
  output logic [CNT_W-1:0]  MISS_COUNT,
  output logic [CNT_W-1:0]  RESOLVED_COUNT
);

  logic [ADDR_W:0]   push_data;
  logic [ADDR_W:0]   head_data;
  logic [ADDR_W-1:0] head_addr;
  logic              head_pred;
  logic              fifo_full;
  logic              fifo_empty;

  logic pop_ok;
  logic mispredict_c;
  logic push_ok;
  logic overflow_c;

  logic              upd_valid_q,      upd_valid_d;
  logic [ADDR_W-1:0] upd_addr_q,       upd_addr_d;
  logic              upd_outcome_q,    upd_outcome_d;
  logic              mispredict_q,     mispredict_d;
  logic              resolve_err_q,    resolve_err_d;
  logic              overflow_q,       overflow_d;
  logic [CNT_W-1:0]  miss_count_q,     miss_count_d;
  logic [CNT_W-1:0]  resolved_count_q, resolved_count_d;

  assign push_data = {PUSH_ADDR, PUSH_PRED};
  assign head_addr = head_data[ADDR_W:1];
  assign head_pred = head_data[0];

  // Accept/pop decisions. A mispredict discards the same-cycle push (it is wrong-path),
  // and a correct pop frees a slot so a push while full is still accepted.
  always_comb begin
    pop_ok       = RESOLVE && !fifo_empty;
    mispredict_c = pop_ok && (TAKEN != head_pred);
    push_ok      = PUSH && !mispredict_c && (!fifo_full || pop_ok);
    overflow_c   = PUSH && !mispredict_c && fifo_full && !pop_ok;
  end

  brq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 1)
  ) u_fifo (
    .clk       (CLOCK),
    .srst      (INIT),
    .push      (push_ok),
    .push_data (push_data),
    .pop       (pop_ok),
    .flush     (mispredict_c),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next values for the registered update port, error strobes and statistics.
  always_comb begin
    upd_valid_d      = pop_ok;
    upd_addr_d       = pop_ok ? head_addr : upd_addr_q;
    upd_outcome_d    = pop_ok ? TAKEN : upd_outcome_q;
    mispredict_d     = mispredict_c;
    resolve_err_d    = RESOLVE && fifo_empty;
    overflow_d       = overflow_q || overflow_c;
    resolved_count_d = resolved_count_q + CNT_W'(pop_ok);
    miss_count_d     = miss_count_q + CNT_W'(mispredict_c);
  end

  // Output and statistics registers; INIT discards everything without emitting updates.
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      upd_valid_q      <= 1'b0;
      upd_addr_q       <= '0;
      upd_outcome_q    <= 1'b0;
      mispredict_q     <= 1'b0;
      resolve_err_q    <= 1'b0;
      overflow_q       <= 1'b0;
      resolved_count_q <= '0;
      miss_count_q     <= '0;
    end else begin
      upd_valid_q      <= upd_valid_d;
      upd_addr_q       <= upd_addr_d;
      upd_outcome_q    <= upd_outcome_d;
      mispredict_q     <= mispredict_d;
      resolve_err_q    <= resolve_err_d;
      overflow_q       <= overflow_d;
      resolved_count_q <= resolved_count_d;
      miss_count_q     <= miss_count_d;
    end
  end

  assign FULL           = fifo_full;
  assign EMPTY          = fifo_empty;
  assign UPD_VALID      = upd_valid_q;
  assign UPD_ADDR       = upd_addr_q;
  assign UPD_OUTCOME    = upd_outcome_q;
  assign MISPREDICT     = mispredict_q;
  assign RESOLVE_ERR    = resolve_err_q;
  assign OVERFLOW       = overflow_q;
  assign MISS_COUNT     = miss_count_q;
  assign RESOLVED_COUNT = resolved_count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        CLOCK;
  logic        INIT;
  logic        PUSH;
  logic [2:0]  PUSH_ADDR;
  logic        PUSH_PRED;
  logic        RESOLVE;
  logic        TAKEN;
  logic        FULL;
  logic        EMPTY;
  logic        UPD_VALID;
  logic [2:0]  UPD_ADDR;
  logic        UPD_OUTCOME;
  logic        MISPREDICT;
  logic        RESOLVE_ERR;
  logic        OVERFLOW;
  logic [15:0] MISS_COUNT;
  logic [15:0] RESOLVED_COUNT;

  branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_W(3), .CNT_W(16)) dut (
    .CLOCK          (CLOCK),
    .INIT           (INIT),
    .PUSH           (PUSH),
    .PUSH_ADDR      (PUSH_ADDR),
    .PUSH_PRED      (PUSH_PRED),
    .RESOLVE        (RESOLVE),
    .TAKEN          (TAKEN),
    .FULL           (FULL),
    .EMPTY          (EMPTY),
    .UPD_VALID      (UPD_VALID),
    .UPD_ADDR       (UPD_ADDR),
    .UPD_OUTCOME    (UPD_OUTCOME),
    .MISPREDICT     (MISPREDICT),
    .RESOLVE_ERR    (RESOLVE_ERR),
    .OVERFLOW       (OVERFLOW),
    .MISS_COUNT     (MISS_COUNT),
    .RESOLVED_COUNT (RESOLVED_COUNT)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Reference model state: in-order list of in-flight branches plus expected outputs.
  brq_entry_t  mq[$];
  logic [15:0] m_resolved;
  logic [15:0] m_miss;
  logic        m_ovf;
  logic        exp_upd_valid;
  logic [2:0]  exp_upd_addr;
  logic        exp_upd_outcome;
  logic        exp_mis;
  logic        exp_err;

  int checks;
  int errors;
  int txn;

  // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
  task automatic step(input logic init, input logic push, input logic [2:0] addr,
                      input logic pred, input logic resolve, input logic taken);
    brq_entry_t e;
    logic flushed;
    INIT = init; PUSH = push; PUSH_ADDR = addr; PUSH_PRED = pred;
    RESOLVE = resolve; TAKEN = taken;
    exp_upd_valid = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
    flushed = 1'b0;
    if (init) begin
      mq.delete();
      m_resolved = '0; m_miss = '0; m_ovf = 1'b0;
      exp_upd_addr = '0; exp_upd_outcome = 1'b0;
    end else begin
      if (resolve) begin
        if (mq.size() == 0) begin
          exp_err = 1'b1;
        end else begin
          e = mq.pop_front();
          exp_upd_valid = 1'b1;
          exp_upd_addr = e.addr;
          exp_upd_outcome = taken;
          m_resolved = m_resolved + 16'd1;
          if (taken != e.pred) begin
            exp_mis = 1'b1;
            m_miss = m_miss + 16'd1;
            mq.delete();
            flushed = 1'b1;
          end
        end
      end
      if (push && !flushed) begin
        if (mq.size() < DEPTH) begin
          e.addr = addr; e.pred = pred;
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge CLOCK);
    #1;
    INIT = 1'b0; PUSH = 1'b0; RESOLVE = 1'b0;
    txn++;
    $display("txn %0d: init=%0b push=%0b addr=%0d pred=%0b resolve=%0b taken=%0b occ=%0d",
             txn, init, push, addr, pred, resolve, taken, mq.size());
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", EMPTY); end
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", FULL); end
    checks++; if (UPD_VALID !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %0b want 0", UPD_VALID); end
    checks++; if (UPD_ADDR !== 3'd0) begin errors++; $display("FAIL reset_upd_addr: got %0d want 0", UPD_ADDR); end
    checks++; if (UPD_OUTCOME !== 1'b0) begin errors++; $display("FAIL reset_upd_outcome: got %0b want 0", UPD_OUTCOME); end
    checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %0b want 0", MISPREDICT); end
    checks++; if (RESOLVE_ERR !== 1'b0) begin errors++; $display("FAIL reset_resolve_err: got %0b want 0", RESOLVE_ERR); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", OVERFLOW); end
    checks++; if (MISS_COUNT !== 16'd0) begin errors++; $display("FAIL reset_miss_count: got %0d want 0", MISS_COUNT); end
    checks++; if (RESOLVED_COUNT !== 16'd0) begin errors++; $display("FAIL reset_resolved_count: got %0d want 0", RESOLVED_COUNT); end
  endtask

  task automatic test_correct_predict();
    step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    checks++; if (EMPTY !== 1'b0) begin errors++; $display("FAIL basic_not_empty: got %0b want 0", EMPTY); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (UPD_VALID !== 1'b1) begin errors++; $display("FAIL basic_upd_valid: got %0b want 1", UPD_VALID); end
    checks++; if (UPD_ADDR !== 3'd5) begin errors++; $display("FAIL basic_upd_addr: got %0d want 5", UPD_ADDR); end
    checks++; if (UPD_OUTCOME !== 1'b1) begin errors++; $display("FAIL basic_upd_outcome: got %0b want 1", UPD_OUTCOME); end
    checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL basic_mispredict: got %0b want 0", MISPREDICT); end
    checks++; if (RESOLVED_COUNT !== 16'd1) begin errors++; $display("FAIL basic_resolved_count: got %0d want 1", RESOLVED_COUNT); end
    checks++; if (MISS_COUNT !== 16'd0) begin errors++; $display("FAIL basic_miss_count: got %0d want 0", MISS_COUNT); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL basic_empty: got %0b want 1", EMPTY); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (UPD_VALID !== 1'b0) begin errors++; $display("FAIL basic_strobe_drop: got %0b want 0", UPD_VALID); end
    checks++; if (UPD_ADDR !== 3'd5) begin errors++; $display("FAIL basic_addr_hold: got %0d want 5", UPD_ADDR); end
    checks++; if (UPD_OUTCOME !== 1'b1) begin errors++; $display("FAIL basic_outcome_hold: got %0b want 1", UPD_OUTCOME); end
  endtask

  task automatic test_mispredict_flush();
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (UPD_VALID !== 1'b1) begin errors++; $display("FAIL flush_upd_valid: got %0b want 1", UPD_VALID); end
    checks++; if (UPD_ADDR !== 3'd1) begin errors++; $display("FAIL flush_upd_addr: got %0d want 1", UPD_ADDR); end
    checks++; if (MISPREDICT !== 1'b1) begin errors++; $display("FAIL flush_mispredict: got %0b want 1", MISPREDICT); end
    checks++; if (MISS_COUNT !== 16'd1) begin errors++; $display("FAIL flush_miss_count: got %0d want 1", MISS_COUNT); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL flush_empty: got %0b want 1", EMPTY); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (UPD_VALID !== 1'b0) begin errors++; $display("FAIL flush_no_wrong_path_update[%0d]: got %0b want 0", i, UPD_VALID); end
      checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL flush_pulse_one_cycle[%0d]: got %0b want 0", i, MISPREDICT); end
    end
  endtask

  task automatic test_full_overflow();
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'(i), 1'(i % 2), 1'b0, 1'b0);
    checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL full_after_four: got %0b want 1", FULL); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL full_no_overflow_yet: got %0b want 0", OVERFLOW); end
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b want 1", OVERFLOW); end
    checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL overflow_still_full: got %0b want 1", FULL); end
    // Head is addr 0 pred 0; resolve it correctly while pushing addr 6.
    step(1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0);
    checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL push_pop_full: got %0b want 1", FULL); end
    checks++; if (UPD_ADDR !== 3'd0) begin errors++; $display("FAIL push_pop_upd_addr: got %0d want 0", UPD_ADDR); end
    checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL push_pop_mispredict: got %0b want 0", MISPREDICT); end
    // Remaining order must be 1,2,3,6 with preds 1,0,1,1.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, mq[0].pred);
      checks++; if (UPD_ADDR !== exp_upd_addr) begin errors++; $display("FAIL drain_addr[%0d]: got %0d want %0d", i, UPD_ADDR, exp_upd_addr); end
      checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL drain_mispredict[%0d]: got %0b want 0", i, MISPREDICT); end
    end
    checks++; if (UPD_ADDR !== 3'd6) begin errors++; $display("FAIL drain_last_is_new: got %0d want 6", UPD_ADDR); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b want 1", EMPTY); end
  endtask

  task automatic test_resolve_err();
    logic [15:0] rc, mc;
    rc = RESOLVED_COUNT; mc = MISS_COUNT;
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (RESOLVE_ERR !== 1'b1) begin errors++; $display("FAIL err_pulse: got %0b want 1", RESOLVE_ERR); end
    checks++; if (UPD_VALID !== 1'b0) begin errors++; $display("FAIL err_no_update: got %0b want 0", UPD_VALID); end
    checks++; if (RESOLVED_COUNT !== rc) begin errors++; $display("FAIL err_resolved_count: got %0d want %0d", RESOLVED_COUNT, rc); end
    checks++; if (MISS_COUNT !== mc) begin errors++; $display("FAIL err_miss_count: got %0d want %0d", MISS_COUNT, mc); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (RESOLVE_ERR !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %0b want 0", RESOLVE_ERR); end
    // Resolve on empty with a simultaneous push: error, push still accepted.
    step(1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
    checks++; if (RESOLVE_ERR !== 1'b1) begin errors++; $display("FAIL err_with_push_pulse: got %0b want 1", RESOLVE_ERR); end
    checks++; if (EMPTY !== 1'b0) begin errors++; $display("FAIL err_with_push_accepted: got %0b want 0", EMPTY); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (UPD_ADDR !== 3'd4) begin errors++; $display("FAIL err_with_push_addr: got %0d want 4", UPD_ADDR); end
  endtask

  task automatic test_wrap();
    logic p [12];
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) p[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 12; i++) begin
      if (i < 10) step(1'b0, 1'b1, 3'(i % 8), p[i], (i >= 2), (i >= 2) ? p[i - 2] : 1'b0);
      else        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, p[i - 2]);
      if (i >= 2) begin
        checks++; if (UPD_ADDR !== 3'((i - 2) % 8)) begin errors++; $display("FAIL wrap_order[%0d]: got %0d want %0d", i - 2, UPD_ADDR, (i - 2) % 8); end
        checks++; if (UPD_OUTCOME !== p[i - 2]) begin errors++; $display("FAIL wrap_outcome[%0d]: got %0b want %0b", i - 2, UPD_OUTCOME, p[i - 2]); end
      end
    end
    checks++; if (RESOLVED_COUNT !== 16'd10) begin errors++; $display("FAIL wrap_resolved_count: got %0d want 10", RESOLVED_COUNT); end
    checks++; if (MISS_COUNT !== 16'd0) begin errors++; $display("FAIL wrap_miss_count: got %0d want 0", MISS_COUNT); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b want 1", EMPTY); end
  endtask

  task automatic test_init_mid();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'(i + 2), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL init_mid_pre_overflow: got %0b want 1", OVERFLOW); end
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL init_mid_empty: got %0b want 1", EMPTY); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL init_mid_overflow: got %0b want 0", OVERFLOW); end
    checks++; if (RESOLVED_COUNT !== 16'd0) begin errors++; $display("FAIL init_mid_resolved_count: got %0d want 0", RESOLVED_COUNT); end
    checks++; if (MISS_COUNT !== 16'd0) begin errors++; $display("FAIL init_mid_miss_count: got %0d want 0", MISS_COUNT); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (UPD_VALID !== 1'b0) begin errors++; $display("FAIL init_mid_discarded[%0d]: got %0b want 0", i, UPD_VALID); end
      checks++; if (RESOLVE_ERR !== 1'b1) begin errors++; $display("FAIL init_mid_err[%0d]: got %0b want 1", i, RESOLVE_ERR); end
    end
  endtask

  task automatic test_random();
    logic init, push, pred, resolve, taken;
    logic [2:0] addr;
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      checks++; if (EMPTY !== (mq.size() == 0)) begin errors++; $display("FAIL rand_empty[%0d]: got %0b want %0b", n, EMPTY, mq.size() == 0); end
      checks++; if (FULL !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rand_full[%0d]: got %0b want %0b", n, FULL, mq.size() == DEPTH); end
      init    = ($urandom_range(0, 99) == 0);
      push    = 1'($urandom_range(0, 99) < 65);
      addr    = 3'($urandom_range(0, 7));
      pred    = 1'($urandom_range(0, 1));
      resolve = 1'($urandom_range(0, 99) < 50);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) taken = mq[0].pred;
      else taken = 1'($urandom_range(0, 1));
      step(init, push, addr, pred, resolve, taken);
      checks++; if (UPD_VALID !== exp_upd_valid) begin errors++; $display("FAIL rand_upd_valid[%0d]: got %0b want %0b", n, UPD_VALID, exp_upd_valid); end
      checks++; if (UPD_ADDR !== exp_upd_addr) begin errors++; $display("FAIL rand_upd_addr[%0d]: got %0d want %0d", n, UPD_ADDR, exp_upd_addr); end
      checks++; if (UPD_OUTCOME !== exp_upd_outcome) begin errors++; $display("FAIL rand_upd_outcome[%0d]: got %0b want %0b", n, UPD_OUTCOME, exp_upd_outcome); end
      checks++; if (MISPREDICT !== exp_mis) begin errors++; $display("FAIL rand_mispredict[%0d]: got %0b want %0b", n, MISPREDICT, exp_mis); end
      checks++; if (RESOLVE_ERR !== exp_err) begin errors++; $display("FAIL rand_resolve_err[%0d]: got %0b want %0b", n, RESOLVE_ERR, exp_err); end
      checks++; if (OVERFLOW !== m_ovf) begin errors++; $display("FAIL rand_overflow[%0d]: got %0b want %0b", n, OVERFLOW, m_ovf); end
      checks++; if (RESOLVED_COUNT !== m_resolved) begin errors++; $display("FAIL rand_resolved_count[%0d]: got %0d want %0d", n, RESOLVED_COUNT, m_resolved); end
      checks++; if (MISS_COUNT !== m_miss) begin errors++; $display("FAIL rand_miss_count[%0d]: got %0d want %0d", n, MISS_COUNT, m_miss); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; txn = 0;
    INIT = 1'b1; PUSH = 1'b0; PUSH_ADDR = '0; PUSH_PRED = 1'b0; RESOLVE = 1'b0; TAKEN = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    test_reset();
    test_correct_predict();
    test_mispredict_flush();
    test_full_overflow();
    test_resolve_err();
    test_wrap();
    test_init_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Execute-side partner of the 2-bit branch predictor. Records each predicted branch at fetch: the table address and the predicted direction.
- Matches each record in order against the actual direction when execute resolves the branch.
- Drives the predictor's update port with the address and actual outcome. Raises a mispredict/flush pulse toward the pipeline and keeps its own mispredict and resolve counts.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of 2, minimum 2.
- ADDR_W, 3, predictor table address width.
- CNT_W, 16, width of the statistics counters.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- INIT  in  1  synchronous active-high reset.
- PUSH  in  1  fetch has issued a predicted branch this cycle.
- PUSH_ADDR  in  ADDR_W  predictor address used for that branch.
- PUSH_PRED  in  1  direction predicted at fetch (1 = taken).
- RESOLVE  in  1  execute has resolved the oldest outstanding branch.
- TAKEN  in  1  actual direction of the resolved branch.
- FULL  out  1  queue holds DEPTH entries; fetch must stall branches.
- EMPTY  out  1  queue holds no entries.
- UPD_VALID  out  1  one-cycle strobe; predictor update valid.
- UPD_ADDR  out  ADDR_W  address to update.
- UPD_OUTCOME  out  1  actual outcome to train with.
- MISPREDICT  out  1  one-cycle flush pulse, aligned with UPD_VALID.
- RESOLVE_ERR  out  1  one-cycle pulse: RESOLVE arrived while EMPTY.
- OVERFLOW  out  1  sticky: PUSH arrived while FULL; cleared only by INIT.
- MISS_COUNT  out  CNT_W  total mispredicts.
- RESOLVED_COUNT  out  CNT_W  total resolved branches.

Behaviour:
- Reset: INIT high at a rising edge clears all state.
  - Head and tail pointers = 0; occupancy = 0; EMPTY = 1, FULL = 0.
  - UPD_VALID, UPD_ADDR, UPD_OUTCOME, MISPREDICT, RESOLVE_ERR, OVERFLOW = 0.
  - Both counters = 0.
  - INIT overrides every other input in the same cycle. INIT mid-operation discards all in-flight entries without producing updates.
- Storage: circular buffer of {addr, pred}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- FULL and EMPTY are combinational from occupancy, so they are valid in the same cycle.
- Push: if PUSH and not FULL, write {PUSH_ADDR, PUSH_PRED} at tail; tail+1; occupancy+1.
  - PUSH while FULL: entry dropped, OVERFLOW set to 1.
- Resolve: if RESOLVE and not EMPTY, read head entry; head+1; occupancy-1.
  - Next cycle (latency 1, registered outputs): UPD_VALID = 1, UPD_ADDR = entry addr, UPD_OUTCOME = TAKEN, MISPREDICT = (TAKEN != entry pred).
  - RESOLVED_COUNT increments. MISS_COUNT increments on mismatch. Both wrap modulo 2^CNT_W.
  - RESOLVE while EMPTY: no pop and no update strobe; RESOLVE_ERR = 1 next cycle.
- Flush: on a mispredicting resolve, every younger entry is wrong-path and is discarded in the same edge.
  - Head = tail = 0; occupancy = 0.
  - A PUSH in that same cycle is also discarded; it does not set OVERFLOW.
- Simultaneous PUSH and RESOLVE with a correct prediction: both take effect; occupancy unchanged.
  - When FULL, this push is accepted, because the pop frees a slot in the same edge.
  - When EMPTY, the resolve is an error, and the push is accepted normally.
- Strobe rules: UPD_VALID, MISPREDICT and RESOLVE_ERR are high for exactly one cycle per event.
  - UPD_ADDR and UPD_OUTCOME hold their last value when UPD_VALID = 0.
- Predictor connection: UPD_ADDR and UPD_OUTCOME connect to the predictor's ADDR/OUTCOME update path, qualified by UPD_VALID.

Decomposition:
- Shared package holds:
  - BRQ_ADDR_W = 3 and BRQ_CNT_W = 16 constants.
  - brq_entry_t typedef {addr, pred}.
  - A clog2 helper for pointer widths.
- One natural sub-module: brq_fifo (circular storage, pointers, occupancy, FULL/EMPTY, flush input).
- Update/mispredict logic and counters stay in branch_resolve_queue.

Test Plan:
- Reset, then PUSH addr=5 pred=1, then RESOLVE TAKEN=1 -> one cycle later UPD_VALID=1, UPD_ADDR=5, UPD_OUTCOME=1, MISPREDICT=0; RESOLVED_COUNT=1, MISS_COUNT=0; EMPTY=1.
- PUSH addrs 1,2,3 pred=0; RESOLVE TAKEN=1 -> UPD_ADDR=1, MISPREDICT=1, MISS_COUNT=1; next cycle EMPTY=1 and entries 2,3 never produce UPD_VALID.
- Fill 4 entries -> FULL=1; PUSH again -> OVERFLOW=1, occupancy stays 4; then PUSH+RESOLVE (correct) in the same cycle -> occupancy stays 4, FULL=1, new entry is the last resolved.
- RESOLVE with EMPTY=1 -> RESOLVE_ERR=1 for one cycle, UPD_VALID=0, counters unchanged.
- Push/resolve 10 correct branches across addresses 0..7 -> pointers wrap, updates come out in push order, RESOLVED_COUNT=10.
- With 3 entries queued, assert INIT for one cycle -> EMPTY=1, OVERFLOW=0, counters=0, and no UPD_VALID is produced afterwards for the discarded entries.
